max_unpool_acc_16: RTL and testbench
====================================

Name: max_unpool_acc_16

Overview:
- Backward and "decode" side of the 16-lane max/argmax reduction, i.e. max-unpooling with gradient routing.
- Consumes a stream of (value, idx) tokens, where idx is the winning-lane index the forward max reduction produced.
- Scatter-accumulates each value into lane idx of a NUM_DATA-lane vector.
- On the group-terminating token, emits the full vector plus a lane-hit mask through a valid/ready output register.
- Sits between the systolic array's gradient/result stream and the writeback path of the systolic system.

Parameters:
- DATA_WIDTH, 8: unsigned width of each value and each accumulator lane.
- NUM_DATA, 16: lanes per window; must be ≥2.
- IDX_WIDTH, $clog2(NUM_DATA): width of the index.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  input token valid
- in_ready  out  1  block can accept a token
- in_data  in  DATA_WIDTH  unsigned value to scatter
- in_idx  in  IDX_WIDTH  destination lane
- in_last  in  1  token closes the current group
- out_valid  out  1  output vector valid
- out_ready  in  1  consumer accepts the vector
- out_data_set  out  DATA_WIDTH*NUM_DATA  lane i at bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
- out_hit_mask  out  NUM_DATA  bit i=1 if lane i received ≥1 token in the group

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Values at reset:
  - accumulator lanes = 0, accumulator mask = 0, state = EMPTY.
  - out_valid = 0, out_data_set = 0, out_hit_mask = 0.
  - in_ready = 1 from the first cycle after reset.
- Input acceptance:
  - Accept = in_valid && in_ready.
  - in_ready = !(out_valid && !out_ready). Combinational from registered out_valid and the out_ready input; no dependency on in_valid.
- On accept with in_idx < NUM_DATA:
  - acc[in_idx] <= acc[in_idx] + in_data, using the add rule under Optional Feature.
  - mask[in_idx] <= 1.
- On accept with in_idx ≥ NUM_DATA (possible only for non-power-of-2 NUM_DATA): token is consumed, no lane or mask changes, in_last is still honoured.
- FSM (accumulator side):
  - EMPTY: a non-last accept goes to PARTIAL. A last accept emits and stays in EMPTY.
  - PARTIAL: a non-last accept stays in PARTIAL. A last accept emits and goes to EMPTY.
- Emit (same edge as the last accept):
  - out_data_set <= accumulator including the last token's contribution; out_hit_mask <= mask including the last token.
  - out_valid <= 1; accumulator and mask cleared to 0.
- Latency: last token accepted at edge N → out_valid=1 visible after edge N, i.e. in cycle N+1.
- Output handshake:
  - out_valid && out_ready pops the vector.
  - If an emit happens in the same cycle, out_valid stays 1 and the new vector is loaded. No bubble, no loss.
  - Otherwise out_valid <= 0 and the data registers hold their stale value.
- Backpressure:
  - While out_valid && !out_ready, in_ready=0. The accumulator and output are frozen.
  - out_data_set and out_hit_mask must not change while out_valid=1 and !out_ready.
- A single-token group (EMPTY + last) is legal: one lane = value, mask one-hot.
- A group whose tokens are all value 0 still emits, and its mask shows the lanes hit.
- Repeated idx within a group accumulates into the same lane.
- Reset asserted mid-group or with a pending output: the partial group and the pending vector are discarded; all state returns to reset values next cycle.

Optional Feature:
- Macro MAX_UNPOOL_SAT_EN.
- Defined: lane add saturates at 2^DATA_WIDTH-1. Saturation is sticky within the group.
- Undefined: lane add wraps modulo 2^DATA_WIDTH.
- Ports and timing are identical in both builds.

Decomposition:
- Shared package max_pool_pkg holds:
  - default DATA_WIDTH=8 and NUM_DATA=16
  - IDX_WIDTH derivation
  - lane slice helper function
  - FSM state typedef (EMPTY, PARTIAL)
- This package is also used by the forward max reduction.
- One natural sub-module, unpool_lane:
  - one lane's accumulator and hit bit.
  - inputs: clear, write-enable, addend.
  - contains the MAX_UNPOOL_SAT_EN add logic.
  - instantiated NUM_DATA times via generate.

Test Plan:
- Single token (data=0x2A, idx=5, last=1), out_ready=1 → next cycle out_valid=1, lane5=0x2A, all other lanes 0, out_hit_mask=0x0020. The following cycle out_valid=0.
- Group (0x10@3, 0x05@3, 0x07@12, last on third), out_ready=1 → lane3=0x15, lane12=0x07, out_hit_mask=0x1008. The next group then starts from all-zero lanes.
- Overflow: (0xF0@0, 0x20@0, last) → lane0=0x10 without the macro, 0xFF with MAX_UNPOOL_SAT_EN.
- Backpressure:
  - Stimulus: emit a vector while out_ready=0 for 4 cycles, with in_valid held high.
  - Required: in_ready=0 and out_data_set stable for those 4 cycles; no token lost.
  - Then raise out_ready: the held vector pops, and the held token is accepted the same cycle.
- Back-to-back single-token groups (0x01@0, 0x02@1, 0x03@2, all last) with out_ready=1 → out_valid high for 3 consecutive cycles carrying lanes 0, 1, 2 respectively.
- Reset mid-operation:
  - Stimulus: reset pulsed for 1 cycle after 2 non-last tokens (0x09@7, 0x04@8); then the single token (0x01@7, last).
  - Required: the output shows lane7=0x01, lane8=0, out_hit_mask=0x0080.

Source files
------------

// File: rtl/max_pool_pkg.sv
// Shared definitions for the forward max reduction and the max-unpool accumulator.
package max_pool_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_NUM_DATA   = 16;
    localparam int DEFAULT_IDX_WIDTH  = $clog2(DEFAULT_NUM_DATA);

    typedef enum logic {
        EMPTY   = 1'b0,
        PARTIAL = 1'b1
    } acc_state_t;

    // Low bit position of a lane inside a packed lane vector.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/max_unpool_acc_16_unpool_lane.sv
// One accumulator lane plus its hit bit. Build option: MAX_UNPOOL_SAT_EN selects a
// saturating add; otherwise the lane add wraps.
module unpool_lane #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] addend,
    output logic [DATA_WIDTH-1:0] next_acc,
    output logic                  next_hit
);

    logic [DATA_WIDTH-1:0] acc;
    logic                  hit;
    logic [DATA_WIDTH-1:0] sum;

`ifdef MAX_UNPOOL_SAT_EN
    logic [DATA_WIDTH:0] wide_sum;
    assign wide_sum = {1'b0, acc} + {1'b0, addend};
    // A carry pins the lane at full scale; later adds cannot move it down.
    assign sum = wide_sum[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : wide_sum[DATA_WIDTH-1:0];
`else
    assign sum = acc + addend;
`endif

    // Next values include this cycle's write so the emit path can capture them.
    assign next_acc = wr_en ? sum : acc;
    assign next_hit = hit | wr_en;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc <= '0;
            hit <= 1'b0;
        end else if (wr_en) begin
            acc <= sum;
            hit <= 1'b1;
        end
    end

endmodule

// File: rtl/max_unpool_acc_16.sv
// Max-unpool accumulator: scatters (value, idx) tokens into lanes and emits the
// lane vector plus hit mask on each group-closing token. Option: MAX_UNPOOL_SAT_EN.
module max_unpool_acc_16
    import max_pool_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_DATA   = DEFAULT_NUM_DATA,
    parameter int IDX_WIDTH  = $clog2(NUM_DATA)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic [IDX_WIDTH-1:0]           in_idx,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH*NUM_DATA-1:0] out_data_set,
    output logic [NUM_DATA-1:0]            out_hit_mask
);

    acc_state_t                    state;
    logic                          accept;
    logic                          emit;
    logic [DATA_WIDTH*NUM_DATA-1:0] next_data;
    logic [NUM_DATA-1:0]           next_hit;

    assign in_ready = !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign emit     = accept && in_last;

    // Out-of-range indices match no lane, so such tokens only advance the group.
    for (genvar i = 0; i < NUM_DATA; i++) begin : g_lane
        unpool_lane #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .clear   (emit),
            .wr_en   (accept && (in_idx == IDX_WIDTH'(i))),
            .addend  (in_data),
            .next_acc(next_data[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH]),
            .next_hit(next_hit[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else if (accept) begin
            state <= in_last ? EMPTY : PARTIAL;
        end
    end

    // A pop and a fresh emit on the same edge reload without a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_data_set <= '0;
            out_hit_mask <= '0;
        end else if (emit) begin
            out_valid    <= 1'b1;
            out_data_set <= next_data;
            out_hit_mask <= next_hit;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_max_unpool_acc_16.sv
// Self-checking bench for max_unpool_acc_16: directed cases plus randomized groups
// against an array-based reference model.
module tb_max_unpool_acc_16;

    localparam int DW = 8;
    localparam int ND = 16;
    localparam int IW = 4;

    typedef struct {
        logic [DW*ND-1:0] data;
        logic [ND-1:0]    mask;
    } expect_t;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic [IW-1:0]     in_idx;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DW*ND-1:0]  out_data_set;
    logic [ND-1:0]     out_hit_mask;

    logic rand_ready_en;
    logic rand_ready_bit;
    logic directed_ready;

    int          check_count;
    int          error_count;
    int          cycle_count;
    int          ref_acc [ND];
    logic [ND-1:0] ref_mask;
    expect_t     exp_q[$];
    bit          due_map[int];

    logic             prev_hold;
    logic [DW*ND-1:0] prev_data;
    logic [ND-1:0]    prev_mask;

    max_unpool_acc_16 dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_idx      (in_idx),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data_set(out_data_set),
        .out_hit_mask(out_hit_mask)
    );

    assign out_ready = rand_ready_en ? rand_ready_bit : directed_ready;

    always #5 clk = ~clk;

    always @(posedge clk) cycle_count <= cycle_count + 1;

    always begin
        @(posedge clk);
        #1;
        rand_ready_bit = ($urandom_range(0, 3) != 0);
    end

    task automatic checkOutput(input string tag, input logic [DW*ND-1:0] observed,
                               input logic [DW*ND-1:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < ND; i++) ref_acc[i] = 0;
        ref_mask = '0;
    endtask

    // Reference behaviour of one accepted token.
    task automatic modelAccept(input int d, input int idx, input logic last);
        expect_t e;
`ifdef MAX_UNPOOL_SAT_EN
        ref_acc[idx] = (ref_acc[idx] + d > 255) ? 255 : ref_acc[idx] + d;
`else
        ref_acc[idx] = (ref_acc[idx] + d) % 256;
`endif
        ref_mask[idx] = 1'b1;
        if (last) begin
            e.data = '0;
            for (int i = 0; i < ND; i++) e.data[i*DW +: DW] = DW'(ref_acc[i]);
            e.mask = ref_mask;
            exp_q.push_back(e);
            due_map[cycle_count + 1] = 1'b1;
            clearModel();
        end
    endtask

    // Presents one token and holds it until accepted; returns just after the accepting edge.
    task automatic applyStimulus(input logic [DW-1:0] d, input logic [IW-1:0] idx,
                                 input logic last);
        int  waited = 0;
        bit  done   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_idx   = idx;
        in_last  = last;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                modelAccept(int'(d), int'(idx), last);
                done = 1;
            end else begin
                waited++;
                if (waited > 200) begin
                    checkOutput("accept_timeout", 0, 1);
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Output monitor: handshake rule, hold stability, latency and scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            checkOutput("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (prev_hold) begin
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_data", out_data_set, prev_data);
                checkOutput("hold_mask", out_hit_mask, prev_mask);
            end
            if (due_map.exists(cycle_count)) begin
                checkOutput("emit_latency", out_valid, 1);
                due_map.delete(cycle_count);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_valid", out_valid, 0);
                end else begin
                    expect_t e;
                    e = exp_q.pop_front();
                    checkOutput("vector_data", out_data_set, e.data);
                    checkOutput("vector_mask", out_hit_mask, e.mask);
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data_set;
            prev_mask = out_hit_mask;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int waited;
        clk            = 1'b0;
        reset          = 1'b1;
        in_valid       = 1'b0;
        in_data        = '0;
        in_idx         = '0;
        in_last        = 1'b0;
        rand_ready_en  = 1'b0;
        directed_ready = 1'b1;
        check_count    = 0;
        error_count    = 0;
        cycle_count    = 0;
        prev_hold      = 1'b0;
        clearModel();

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_valid", out_valid, 0);
        checkOutput("reset_data", out_data_set, 0);
        checkOutput("reset_mask", out_hit_mask, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Single token group.
        applyStimulus(8'h2A, 4'd5, 1'b1);
        @(negedge clk);
        checkOutput("single_valid", out_valid, 1);
        checkOutput("single_data", out_data_set, {{(DW*ND-8){1'b0}}, 8'h2A} << 40);
        checkOutput("single_mask", out_hit_mask, 16'h0020);
        @(negedge clk);
        checkOutput("single_drop", out_valid, 0);
        @(posedge clk);
        #1;

        // Multi-token group with a repeated lane.
        applyStimulus(8'h10, 4'd3, 1'b0);
        applyStimulus(8'h05, 4'd3, 1'b0);
        applyStimulus(8'h07, 4'd12, 1'b1);
        @(negedge clk);
        checkOutput("group_lane3", out_data_set[31:24], 8'h15);
        checkOutput("group_lane12", out_data_set[103:96], 8'h07);
        checkOutput("group_mask", out_hit_mask, 16'h1008);
        @(posedge clk);
        #1;

        // Lane overflow.
        applyStimulus(8'hF0, 4'd0, 1'b0);
        applyStimulus(8'h20, 4'd0, 1'b1);
        @(negedge clk);
`ifdef MAX_UNPOOL_SAT_EN
        checkOutput("overflow_lane0", out_data_set[7:0], 8'hFF);
`else
        checkOutput("overflow_lane0", out_data_set[7:0], 8'h10);
`endif
        @(posedge clk);
        #1;

        // All-zero group still emits its mask.
        applyStimulus(8'h00, 4'd2, 1'b0);
        applyStimulus(8'h00, 4'd15, 1'b1);
        @(negedge clk);
        checkOutput("zero_mask", out_hit_mask, 16'h8004);
        @(posedge clk);
        #1;

        // Backpressure with a token waiting.
        directed_ready = 1'b0;
        applyStimulus(8'h33, 4'd4, 1'b1);
        fork
            applyStimulus(8'h44, 4'd9, 1'b1);
            begin
                repeat (4) begin
                    @(negedge clk);
                    checkOutput("bp_in_ready", in_ready, 0);
                    checkOutput("bp_lane4", out_data_set[39:32], 8'h33);
                end
                @(posedge clk);
                #1;
                directed_ready = 1'b1;
            end
        join
        @(negedge clk);
        checkOutput("bp_next_valid", out_valid, 1);
        checkOutput("bp_next_lane9", out_data_set[79:72], 8'h44);
        @(posedge clk);
        #1;

        // Back-to-back single-token groups.
        applyStimulus(8'h01, 4'd0, 1'b1);
        applyStimulus(8'h02, 4'd1, 1'b1);
        applyStimulus(8'h03, 4'd2, 1'b1);
        @(negedge clk);
        checkOutput("b2b_last_mask", out_hit_mask, 16'h0004);
        @(posedge clk);
        #1;

        // Reset in the middle of a group.
        applyStimulus(8'h09, 4'd7, 1'b0);
        applyStimulus(8'h04, 4'd8, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clearModel();
        exp_q.delete();
        due_map.delete();
        @(negedge clk);
        checkOutput("midreset_valid", out_valid, 0);
        checkOutput("midreset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        applyStimulus(8'h01, 4'd7, 1'b1);
        @(negedge clk);
        checkOutput("midreset_lane7", out_data_set[63:56], 8'h01);
        checkOutput("midreset_lane8", out_data_set[71:64], 8'h00);
        checkOutput("midreset_mask", out_hit_mask, 16'h0080);
        @(posedge clk);
        #1;

        // Randomized groups under random output backpressure.
        rand_ready_en = 1'b1;
        for (int g = 0; g < 40; g++) begin
            n = $urandom_range(1, 5);
            for (int t = 0; t < n; t++) begin
                applyStimulus(DW'($urandom_range(0, 255)), IW'($urandom_range(0, ND - 1)),
                              (t == n - 1));
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
        end

        // Drain whatever is still pending.
        rand_ready_en  = 1'b0;
        directed_ready = 1'b1;
        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        checkOutput("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
